// File: rtl/syncfifo_flags.sv
// Single-clock FIFO with arbitrary depth, occupancy counter, programmable almost-full/empty
// thresholds, overflow/underflow pulses and selectable registered or FWFT read port.
module syncfifo_flags #(
    parameter int unsigned DT_WIDTH   = 8,
    parameter int unsigned F_DEPTH    = 16,
    parameter int unsigned FADD_WIDTH = $clog2(F_DEPTH),
    parameter int unsigned CNT_WIDTH  = $clog2(F_DEPTH + 1),
    parameter int unsigned AF_THRESH  = F_DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrt_en,
    input  logic [DT_WIDTH-1:0]  wrt_dt,
    input  logic                 rd_en,
    output logic [DT_WIDTH-1:0]  rd_dt,
    output logic                 rd_vld,
    output logic                 f_empty,
    output logic                 f_full,
    output logic                 f_afull,
    output logic                 f_aempty,
    output logic [CNT_WIDTH-1:0] f_count,
    output logic                 ovf,
    output logic                 udf
);

    logic [DT_WIDTH-1:0]   mem [F_DEPTH];
    logic [FADD_WIDTH-1:0] wrt_pntr;
    logic [FADD_WIDTH-1:0] rd_pntr;
    logic                  rd_acc;
    logic                  wr_acc;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [FADD_WIDTH-1:0] bump(input logic [FADD_WIDTH-1:0] p);
        return (p == FADD_WIDTH'(F_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        f_empty  = (f_count == '0);
        f_full   = (f_count == CNT_WIDTH'(F_DEPTH));
        f_afull  = (f_count >= CNT_WIDTH'(AF_THRESH));
        f_aempty = (f_count <= CNT_WIDTH'(AE_THRESH));
        rd_acc   = rd_en & ~f_empty;
        wr_acc   = wrt_en & (~f_full | rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrt_pntr <= '0;
            rd_pntr  <= '0;
            f_count  <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            if (wr_acc) wrt_pntr <= bump(wrt_pntr);
            if (rd_acc) rd_pntr  <= bump(rd_pntr);
            case ({wr_acc, rd_acc})
                2'b10:   f_count <= f_count + CNT_WIDTH'(1);
                2'b01:   f_count <= f_count - CNT_WIDTH'(1);
                default: f_count <= f_count;
            endcase
            ovf <= wrt_en & ~wr_acc;
            udf <= rd_en & ~rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wrt_pntr] <= wrt_dt;
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DT_WIDTH-1:0] dt_q;
        logic                vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dt_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= rd_acc;
                if (rd_acc) dt_q <= mem[rd_pntr];
            end
        end

        assign rd_dt  = dt_q;
        assign rd_vld = vld_q;
    end else begin : g_fwft_read
        assign rd_dt  = mem[rd_pntr];
        assign rd_vld = ~f_empty;
    end

endmodule

// File: doc/syncfifo_flags.md
Name: syncfifo_flags

Overview:
- Parametrised next-generation synchronous FIFO: single clock, arbitrary (non-power-of-2) depth, occupancy counter, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses.
- Selectable read mode: registered read (standard) or first-word-fall-through (FWFT).
- Drop-in buffer between streaming producers and consumers in the same clock domain; replaces the fixed-depth FIFO where flag lookahead or odd depths are needed.

Parameters:
- DT_WIDTH, 8, data word width in bits (>=1).
- F_DEPTH, 16, number of storage entries (>=2, need not be a power of 2).
- FADD_WIDTH, $clog2(F_DEPTH), pointer width.
- CNT_WIDTH, $clog2(F_DEPTH+1), occupancy counter width.
- AF_THRESH, F_DEPTH-2, f_afull asserts when count >= AF_THRESH (1..F_DEPTH).
- AE_THRESH, 2, f_aempty asserts when count <= AE_THRESH (0..F_DEPTH-1).
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wrt_en  in  1  write request.
- wrt_dt  in  DT_WIDTH  write data.
- rd_en  in  1  read request (pop).
- rd_dt  out  DT_WIDTH  read data.
- rd_vld  out  1  rd_dt is valid.
- f_empty  out  1  count == 0.
- f_full  out  1  count == F_DEPTH.
- f_afull  out  1  count >= AF_THRESH.
- f_aempty  out  1  count <= AE_THRESH.
- f_count  out  CNT_WIDTH  current occupancy.
- ovf  out  1  one-cycle pulse: a write was rejected.
- udf  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (rst=1 at an edge):
  - wrt_pntr, rd_pntr, f_count go to 0. rd_dt goes to 0. rd_vld, ovf and udf go to 0.
  - Flags after reset: f_empty=1, f_aempty=1, f_full=0, f_afull=0 (for AE_THRESH>=0, AF_THRESH>=1).
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data. Reset has priority over rd_en and wrt_en in the same cycle.
- Read acceptance: rd_acc = rd_en & !f_empty.
- Write acceptance: wr_acc = wrt_en & (!f_full | rd_acc). A write into a full FIFO is allowed when a read is accepted in the same cycle.
- Simultaneous read and write on an empty FIFO: the write is accepted; the read is rejected and udf pulses. In FWFT mode this holds even though data is not yet visible.
- Pointers:
  - Each pointer increments by 1 on acceptance and wraps from F_DEPTH-1 to 0 (explicit compare; no reliance on a power-of-2 depth).
  - Full and empty are derived from f_count, not from pointer compare.
- Counter update:
  - f_count += 1 on wr_acc & !rd_acc.
  - f_count -= 1 on rd_acc & !wr_acc.
  - Otherwise f_count is unchanged.
- All status flags are combinational from the f_count register only. They never depend on the current-cycle rd_en or wrt_en.
- Memory: on wr_acc, mem[wrt_pntr] <= wrt_dt. Write-to-read visibility latency is 1 cycle: a word written at edge N is readable from cycle N+1.
- FWFT=0 (registered read):
  - On rd_acc, rd_dt <= mem[rd_pntr] and rd_vld <= 1 at the next edge.
  - Otherwise rd_vld <= 0 and rd_dt holds its last value.
  - Read latency is 1 cycle.
- FWFT=1 (first-word-fall-through):
  - rd_dt = mem[rd_pntr] and rd_vld = !f_empty, both combinational from registers.
  - rd_en acts as acknowledge/pop; the next word appears the cycle after the pop.
- Error pulses:
  - ovf <= wrt_en & !wr_acc.
  - udf <= rd_en & !rd_acc.
  - Both are registered, high for exactly one cycle per rejected request, and never set during reset.
- Boundary invariant: f_count stays within 0..F_DEPTH under any stimulus; no data is overwritten or lost except through reset.

Test Plan:
- Fill and drain, F_DEPTH=16, FWFT=0:
  - Stimulus: write 0x00..0x0F, then read 16 words.
  - Required: f_full=1 after the 16th write and f_count=16. Reads return 0x00..0x0F in order, each with rd_vld one cycle after rd_en. f_empty=1 at the end.
- Overflow/underflow:
  - Stimulus: with the FIFO full, wrt_en=1 and rd_en=0 for 1 cycle.
  - Required: ovf high for 1 cycle, f_count stays 16, no data corrupted.
  - Stimulus: with the FIFO empty, rd_en=1.
  - Required: udf pulses and rd_vld stays 0.
- Simultaneous read/write:
  - Stimulus: at full, wrt_en=rd_en=1 with data 0xA5.
  - Required: both accepted, f_count stays 16, no ovf, 0xA5 read last.
  - Stimulus: at empty, wrt_en=rd_en=1.
  - Required: f_count becomes 1 and udf pulses.
- Non-power-of-2 wrap, F_DEPTH=5:
  - Stimulus: stream 23 words with interleaved reads, keeping occupancy between 1 and 5.
  - Required: output order equals input order, pointers wrap 4->0, f_full exactly at count 5.
- Thresholds, AF_THRESH=14, AE_THRESH=2:
  - Required: f_afull rises when count reaches 14 and falls at 13. f_aempty is high for counts 0..2 and low at 3.
- FWFT=1 and reset mid-operation:
  - Stimulus: write 0x11.
  - Required: rd_dt=0x11 with rd_vld=1 the next cycle, without rd_en.
  - Stimulus: load 7 words, then pulse rst for 1 cycle during concurrent writes.
  - Required: f_count=0, f_empty=1, rd_vld=0 the next cycle; the stale word is never output.
